// File: rtl/fir_pkg.sv
// Shared FIR definitions: FSM state codes, address-width helper,
// rounding constant and saturation bounds for a given width.
package fir_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_MAC  = 2'd1;
  localparam state_t S_OUT  = 2'd2;

  // Bits needed to index n entries (at least one).
  function automatic int unsigned addr_w(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned v = n - 1; v != 0; v = v >> 1) w++;
    return (w == 0) ? 1 : w;
  endfunction

  // Half-LSB of the output scale, added before the arithmetic shift.
  function automatic longint rnd_const(input int unsigned shift);
    return (shift == 0) ? 64'sd0 : (64'sd1 <<< (shift - 1));
  endfunction

  // Largest value representable in a w-bit signed word.
  function automatic longint sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a w-bit signed word.
  function automatic longint sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate: acc <= acc + x*c when en, cleared by clr.
// Ports: clk, reset (sync, active-high), clr, en, x, c, acc (registered).
module fir_mac_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned ACC_W  = 37
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [COEF_W-1:0] c,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;

  // Full-precision product; both operands sign-extended first.
  assign prod = PROD_W'(x) * PROD_W'(c);

  always_ff @(posedge clk) begin
    if (reset)     acc <= '0;
    else if (clr)  acc <= '0;
    else if (en)   acc <= acc + ACC_W'(prod);
  end

endmodule

// File: rtl/fir_filter_mac.sv
// Parametrised FIR filter using one time-multiplexed MAC unit.
// A sample accepted in IDLE is shifted into the delay line, then NTAPS
// MAC cycles run, then the rounded/shifted result is registered with a
// one-cycle out_valid pulse.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   in_valid/in_ready/in_sample   sample input handshake
//   out_valid/out_sample/out_sat  result pulse, held sample, clamp flag
//   coef_we/coef_addr/coef_wdata  coefficient write port (IDLE only)
// Build option: define FIR_SAT_EN to clamp results to the DATA_W range
// and report clamping on out_sat; otherwise results wrap and out_sat=0.
module fir_filter_mac
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned NTAPS     = 32,
  parameter int unsigned OUT_SHIFT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   in_sample,
  output logic                       out_valid,
  output logic signed [DATA_W-1:0]   out_sample,
  output logic                       out_sat,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]   coef_wdata
);

  localparam int unsigned AW    = addr_w(NTAPS);
  localparam int unsigned ACC_W = DATA_W + COEF_W + AW;

  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(sat_max(COEF_W));
  localparam logic signed [ACC_W-1:0]  RND      = ACC_W'(rnd_const(OUT_SHIFT));

  state_t state, state_nx;

  logic signed [DATA_W-1:0] x_q [NTAPS];
  logic signed [COEF_W-1:0] c_q [NTAPS];
  logic [AW-1:0]            k_q;

  logic                     accept;
  logic                     coef_wr;
  logic                     last_tap;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_rnd;
  logic signed [DATA_W-1:0] res;
  logic                     sat_c;

  assign in_ready = !reset && (state == S_IDLE);
  assign accept   = in_valid && in_ready;
  assign coef_wr  = coef_we && in_ready;
  assign last_tap = (k_q == AW'(NTAPS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept)   state_nx = S_MAC;
      S_MAC:   if (last_tap) state_nx = S_OUT;
      S_OUT:                 state_nx = S_IDLE;
      default:               state_nx = S_IDLE;
    endcase
  end

  // Single shared MAC; operands selected by the tap counter.
  fir_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (state == S_MAC),
    .x     (x_q[k_q]),
    .c     (c_q[k_q]),
    .acc   (acc)
  );

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(DATA_W));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(DATA_W));

  logic signed [ACC_W-1:0] acc_shr;

  // Round, shift, then clamp into the output range.
  always_comb begin
    acc_rnd = acc + RND;
    acc_shr = acc_rnd >>> OUT_SHIFT;
    res     = DATA_W'(acc_shr);
    sat_c   = 1'b0;
    if (acc_shr > SAT_HI) begin
      res   = DATA_W'(SAT_HI);
      sat_c = 1'b1;
    end else if (acc_shr < SAT_LO) begin
      res   = DATA_W'(SAT_LO);
      sat_c = 1'b1;
    end
  end
`else
  // Round, shift, keep the low DATA_W bits (wrap-around).
  always_comb begin
    acc_rnd = acc + RND;
    res     = DATA_W'(acc_rnd >>> OUT_SHIFT);
    sat_c   = 1'b0;
  end
`endif

  // Delay line, coefficient file, tap counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        x_q[i] <= '0;
        c_q[i] <= '0;
      end
      c_q[0]     <= COEF_ONE;
      k_q        <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      out_sat    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      // Write lands at the accept edge, so the MAC sees the new value.
      if (coef_wr) c_q[coef_addr] <= coef_wdata;
      if (accept) begin
        x_q[0] <= in_sample;
        for (int unsigned i = 1; i < NTAPS; i++) x_q[i] <= x_q[i-1];
        k_q <= '0;
      end else if (state == S_MAC) begin
        k_q <= k_q + AW'(1);
      end
      if (state == S_OUT) begin
        out_valid  <= 1'b1;
        out_sample <= res;
        out_sat    <= sat_c;
      end
    end
  end

endmodule

// File: tb/tb_fir_filter_mac.sv
`timescale 1ns/1ps
module tb_fir_filter_mac;

  localparam int unsigned DW  = 16;
  localparam int unsigned CW  = 16;
  localparam int unsigned NT  = 4;
  localparam int unsigned SH  = 15;
  localparam int unsigned AWT = 2;

  localparam longint MAXV = (longint'(1) <<< (DW - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (DW - 1));

  typedef struct {
    logic signed [DW-1:0] s;
    logic                 sat;
    int                   cyc;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_sample;
  logic                 out_valid;
  logic signed [DW-1:0] out_sample;
  logic                 out_sat;
  logic                 coef_we;
  logic [AWT-1:0]       coef_addr;
  logic signed [CW-1:0] coef_wdata;

  always #5 clk = ~clk;

  fir_filter_mac #(
    .DATA_W    (DW),
    .COEF_W    (CW),
    .NTAPS     (NT),
    .OUT_SHIFT (SH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sample  (in_sample),
    .out_valid  (out_valid),
    .out_sample (out_sample),
    .out_sat    (out_sat),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata)
  );

  // Reference model state: sample history, coefficients, busy countdown.
  int   mh [NT];
  int   mc [NT];
  int   busy = 0;
  int   cyc  = 0;
  exp_t q [$];
  logic signed [DW-1:0] last_out = '0;
  logic                 last_sat = 1'b0;

  int checks = 0;
  int errors = 0;

  function automatic exp_t predict(input int due);
    exp_t   e;
    longint acc;
    acc = 0;
    for (int k = 0; k < NT; k++) acc += longint'(mh[k]) * longint'(mc[k]);
    acc = (acc + (longint'(1) <<< (SH - 1))) >>> SH;
`ifdef FIR_SAT_EN
    if (acc > MAXV) begin
      e.s = DW'(MAXV); e.sat = 1'b1;
    end else if (acc < MINV) begin
      e.s = DW'(MINV); e.sat = 1'b1;
    end else begin
      e.s = DW'(acc); e.sat = 1'b0;
    end
`else
    e.s   = DW'(acc);
    e.sat = 1'b0;
`endif
    e.cyc = due;
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NT; k++) begin
      mh[k] = 0;
      mc[k] = 0;
    end
    mc[0]    = (1 << (CW - 1)) - 1;
    busy     = 0;
    q.delete();
    last_out = '0;
    last_sat = 1'b0;
  endtask

  // Model: observes inputs at each rising edge and predicts results.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      model_reset();
    end else if (busy == 0) begin
      if (coef_we) mc[coef_addr] = int'(coef_wdata);
      if (in_valid) begin
        for (int k = NT - 1; k > 0; k--) mh[k] = mh[k-1];
        mh[0] = int'(in_sample);
        q.push_back(predict(cyc + NT + 1));
        busy = NT + 1;
      end
    end else begin
      busy--;
    end
  end

  // Monitor: checks ready, output pulses and held output between pulses.
  always @(negedge clk) begin
    exp_t e;
    logic exp_ready;
    exp_ready = !reset && (busy == 0);
    checks++;
    if (in_ready !== exp_ready) begin
      errors++;
      $display("FAIL in_ready cyc=%0d: got %b want %b", cyc, in_ready, exp_ready);
    end
    if (out_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out cyc=%0d: got out_valid=1 sample=%0d want no output", cyc, out_sample);
      end else begin
        e = q.pop_front();
        if (out_sample !== e.s || out_sat !== e.sat || cyc != e.cyc) begin
          errors++;
          $display("FAIL result cyc=%0d: got sample=%0d sat=%b at cyc %0d want sample=%0d sat=%b at cyc %0d",
                   cyc, out_sample, out_sat, cyc, e.s, e.sat, e.cyc);
        end
        last_out = e.s;
        last_sat = e.sat;
      end
    end else begin
      checks++;
      if (out_valid !== 1'b0 || out_sample !== last_out || out_sat !== last_sat) begin
        errors++;
        $display("FAIL hold cyc=%0d: got valid=%b sample=%0d sat=%b want valid=0 sample=%0d sat=%b",
                 cyc, out_valid, out_sample, out_sat, last_out, last_sat);
      end
      if (q.size() > 0 && cyc >= q[0].cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_out cyc=%0d: got no out_valid want sample=%0d", cyc, q[0].s);
        void'(q.pop_front());
      end
    end
  end

  task automatic send(input int s);
    int n;
    n = 0;
    in_valid  = 1'b1;
    in_sample = DW'(s);
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles want ready", n);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic write_coef(input int a, input int d);
    coef_we    = 1'b1;
    coef_addr  = AWT'(a);
    coef_wdata = CW'(d);
    @(negedge clk);
    coef_we    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results want 0", q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_sample  = '0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Identity with reset coefficients.
    send(1000);
    send(-1000);
    drain();

    // Four-tap moving average on a step.
    do_reset();
    for (int a = 0; a < NT; a++) write_coef(a, 'h2000);
    repeat (5) send(4000);
    drain();

    // Saturation / wrap on two full-scale samples.
    do_reset();
    write_coef(1, 'h7FFF);
    write_coef(2, 0);
    write_coef(3, 0);
    send('h7FFF);
    send('h7FFF);
    drain();

    // in_valid held high: only idle-cycle samples get in.
    do_reset();
    in_valid = 1'b1;
    repeat (40) begin
      in_sample = DW'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    drain();

    // Coefficient write while busy is dropped.
    do_reset();
    send(1234);
    write_coef(0, 0);
    send(777);
    drain();

    // Reset during the second MAC cycle aborts the result.
    send(300);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send(500);
    drain();
    for (int a = 1; a < NT; a++) write_coef(a, 'h7FFF);
    send(-20);
    drain();

    // Random traffic with coefficient writes and occasional resets.
    repeat (300) begin
      in_valid   = ($urandom_range(0, 1) == 1);
      in_sample  = DW'($urandom);
      coef_we    = ($urandom_range(0, 7) == 0);
      coef_addr  = AWT'($urandom);
      coef_wdata = CW'($urandom);
      reset      = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
